// File: rtl/rv32i_writeback_stage.sv
// Writeback merge of single-cycle EX results and buffered LSU load results into
// one registered register-file write per cycle, plus a load busy scoreboard.
module rv32i_writeback_stage #(
  parameter int XLEN_P       = 32,
  parameter int DEPTH_P      = 32,
  parameter int ADDR_WIDTH_P = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ex_valid_i,
  input  logic [ADDR_WIDTH_P-1:0] ex_rd_addr_i,
  input  logic [XLEN_P-1:0]       ex_wdata_i,
  input  logic                    lsu_valid_i,
  output logic                    lsu_ready_o,
  input  logic [ADDR_WIDTH_P-1:0] lsu_rd_addr_i,
  input  logic [XLEN_P-1:0]       lsu_wdata_i,
  input  logic                    issue_lsu_i,
  input  logic [ADDR_WIDTH_P-1:0] issue_rd_i,
  input  logic [ADDR_WIDTH_P-1:0] chk_rs1_i,
  input  logic [ADDR_WIDTH_P-1:0] chk_rs2_i,
  input  logic [ADDR_WIDTH_P-1:0] chk_rd_i,
  output logic                    hazard_o,
  output logic [DEPTH_P-1:0]      busy_o,
  output logic                    rd_we_o,
  output logic [ADDR_WIDTH_P-1:0] rd_addr_o,
  output logic [XLEN_P-1:0]       rd_wdata_o
);

  logic                    ex_write;
  logic                    lsu_accept;
  logic                    hold_drain;
  logic                    lsu_commit;
  logic                    issue_write;
  logic                    hold_valid_q;
  logic [ADDR_WIDTH_P-1:0] hold_addr_q;
  logic [XLEN_P-1:0]       hold_data_q;
  logic [DEPTH_P-1:0]      busy_q;
  logic [DEPTH_P-1:0]      busy_d;

  // Register 0 never reads as busy, whatever the vector holds.
  function automatic logic is_busy(input logic [DEPTH_P-1:0]      vec,
                                   input logic [ADDR_WIDTH_P-1:0] addr);
    is_busy = 1'b0;
    for (int i = 1; i < DEPTH_P; i++) begin
      if (32'(addr) == i) is_busy = vec[i];
    end
  endfunction

  assign ex_write    = ex_valid_i && (ex_rd_addr_i != '0);
  assign issue_write = issue_lsu_i && (issue_rd_i != '0);
  assign hold_drain  = hold_valid_q && !ex_write;
  assign lsu_commit  = hold_drain && (hold_addr_q != '0);
  assign lsu_ready_o = rst_ni && (!hold_valid_q || !ex_write);
  assign lsu_accept  = lsu_valid_i && lsu_ready_o;

  assign hazard_o = is_busy(busy_q, chk_rs1_i) | is_busy(busy_q, chk_rs2_i) |
                    is_busy(busy_q, chk_rd_i);
  assign busy_o   = busy_q;

  // Set is applied after clear so a newly issued load keeps its register busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < DEPTH_P; i++) begin
      if (lsu_commit && (32'(hold_addr_q) == i)) busy_d[i] = 1'b0;
      if (issue_write && (32'(issue_rd_i) == i)) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (lsu_accept)      hold_valid_q <= 1'b1;
      else if (hold_drain) hold_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (lsu_accept) begin
      hold_addr_q <= lsu_rd_addr_i;
      hold_data_q <= lsu_wdata_i;
    end
  end

  // EX has strict priority; the address/data outputs hold when nothing is written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_we_o    <= 1'b0;
      rd_addr_o  <= '0;
      rd_wdata_o <= '0;
    end else begin
      rd_we_o <= ex_write || lsu_commit;
      if (ex_write) begin
        rd_addr_o  <= ex_rd_addr_i;
        rd_wdata_o <= ex_wdata_i;
      end else if (lsu_commit) begin
        rd_addr_o  <= hold_addr_q;
        rd_wdata_o <= hold_data_q;
      end
    end
  end

`ifndef SYNTHESIS
  localparam logic [ADDR_WIDTH_P:0] DEPTH_LIMIT = (ADDR_WIDTH_P + 1)'(DEPTH_P);

  function automatic logic addr_ok(input logic [ADDR_WIDTH_P-1:0] addr);
    addr_ok = {1'b0, addr} < DEPTH_LIMIT;
  endfunction

  a_ex_to_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ex_write |-> !is_busy(busy_q, ex_rd_addr_i));

  a_addr_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!ex_valid_i || addr_ok(ex_rd_addr_i)) && (!lsu_valid_i || addr_ok(lsu_rd_addr_i)) &&
    (!issue_lsu_i || addr_ok(issue_rd_i)) && addr_ok(chk_rs1_i) &&
    addr_ok(chk_rs2_i) && addr_ok(chk_rd_i));

  a_lsu_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ($past(rst_ni) && $past(lsu_valid_i && !lsu_ready_o)) |-> lsu_valid_i);
`endif

endmodule

// File: tb/tb_rv32i_writeback_stage.sv
// Randomized and directed bench for rv32i_writeback_stage against a queue-based
// reference model of the writeback, hold buffer and scoreboard rules.
module tb_rv32i_writeback_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            ex_valid;
  logic [AW-1:0]   ex_rd;
  logic [XLEN-1:0] ex_wdata;
  logic            lsu_valid;
  logic            lsu_ready_o;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_wdata;
  logic            issue_lsu;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   chk_rs1, chk_rs2, chk_rd;
  logic            hazard_o;
  logic [DEPTH-1:0] busy_o;
  logic            rd_we_o;
  logic [AW-1:0]   rd_addr_o;
  logic [XLEN-1:0] rd_wdata_o;

  always #5 clk = ~clk;

  rv32i_writeback_stage #(.XLEN_P(XLEN), .DEPTH_P(DEPTH), .ADDR_WIDTH_P(AW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid), .ex_rd_addr_i(ex_rd), .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_addr_i(lsu_rd), .lsu_wdata_i(lsu_wdata),
    .issue_lsu_i(issue_lsu), .issue_rd_i(issue_rd),
    .chk_rs1_i(chk_rs1), .chk_rs2_i(chk_rs2), .chk_rd_i(chk_rd),
    .hazard_o(hazard_o), .busy_o(busy_o),
    .rd_we_o(rd_we_o), .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t             m_hold[$];
  bit              m_busy[DEPTH];
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  bit              accepted;

  function automatic void model_reset();
    m_hold.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic clr_in();
    ex_valid  = 1'b0; ex_rd = '0; ex_wdata = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0;
    issue_lsu = 1'b0; issue_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
  endtask

  // Called right after a falling edge with inputs already applied.
  task automatic step();
    bit  exw, ready;
    wb_t e;
    #1;
    if (!rst_ni) model_reset();
    exw   = ex_valid && (ex_rd != 0);
    ready = rst_ni && !((m_hold.size() != 0) && exw);
    check("lsu_ready", 32'(lsu_ready_o), 32'(ready));
    check("hazard", 32'(hazard_o), 32'(m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd]));
    accepted = lsu_valid && ready;
    @(posedge clk);
    if (rst_ni) begin
      m_we = 1'b0;
      if (exw) begin
        m_we = 1'b1; m_addr = ex_rd; m_data = ex_wdata;
      end else if (m_hold.size() != 0) begin
        e = m_hold.pop_front();
        if (e.addr != 0) begin
          m_we = 1'b1; m_addr = e.addr; m_data = e.data;
          m_busy[e.addr] = 1'b0;
        end
      end
      if (issue_lsu && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (accepted) m_hold.push_back('{addr: lsu_rd, data: lsu_wdata});
    end
    #1;
    check("rd_we", 32'(rd_we_o), 32'(m_we));
    check("rd_addr", 32'(rd_addr_o), 32'(m_addr));
    check("rd_wdata", rd_wdata_o, m_data);
    check("busy", busy_o, busy_vec());
    @(negedge clk);
  endtask

  initial begin : main
    bit            pending;
    logic [AW-1:0] outst[$];
    model_reset();
    clr_in();
    rst_ni = 1'b0;
    @(negedge clk);
    step();
    step();
    rst_ni = 1'b1;
    step();

    // EX write to x5.
    ex_valid = 1'b1; ex_rd = 5; ex_wdata = 32'hDEADBEEF;
    step();
    check("ex_we_const", 32'(rd_we_o), 32'd1);
    check("ex_data_const", rd_wdata_o, 32'hDEADBEEF);
    clr_in();
    step();
    check("ex_one_cycle", 32'(rd_we_o), 32'd0);

    // Load to x7, hazard until commit.
    issue_lsu = 1'b1; issue_rd = 7;
    step();
    clr_in(); chk_rs1 = 7;
    step();
    check("x7_hazard_const", 32'(hazard_o), 32'd1);
    lsu_valid = 1'b1; lsu_rd = 7; lsu_wdata = 32'h1234;
    step();
    lsu_valid = 1'b0;
    step();
    check("x7_data_const", rd_wdata_o, 32'h1234);
    check("x7_busy_const", 32'(busy_o[7]), 32'd0);
    #1 check("x7_hazard_clear", 32'(hazard_o), 32'd0);
    clr_in();
    step();

    // LSU held while EX writes three times.
    lsu_valid = 1'b1; lsu_rd = 9; lsu_wdata = 32'hAAAA5555;
    ex_valid = 1'b1; ex_rd = 10; ex_wdata = 32'h10;
    step();
    lsu_valid = 1'b0;
    for (int i = 11; i <= 13; i++) begin
      ex_rd = AW'(i); ex_wdata = 32'(i);
      #1 check("starve_ready", 32'(lsu_ready_o), 32'd0);
      step();
      check("starve_order", 32'(rd_addr_o), 32'(i));
    end
    clr_in();
    step();
    check("starve_commit", 32'(rd_addr_o), 32'd9);

    // Back-to-back LSU results to x1..x3.
    for (int i = 1; i <= 3; i++) begin
      lsu_valid = 1'b1; lsu_rd = AW'(i); lsu_wdata = 32'(i * 32'h11);
      step();
    end
    clr_in();
    step();
    step();

    // Commit of x4 on the edge a new load to x4 issues.
    issue_lsu = 1'b1; issue_rd = 4;
    step();
    clr_in(); lsu_valid = 1'b1; lsu_rd = 4; lsu_wdata = 32'h44;
    step();
    clr_in(); issue_lsu = 1'b1; issue_rd = 4;
    step();
    check("x4_set_wins", 32'(busy_o[4]), 32'd1);
    clr_in(); lsu_valid = 1'b1; lsu_rd = 4; lsu_wdata = 32'h45;
    step();
    clr_in();
    step();

    // Writes to x0 are suppressed.
    ex_valid = 1'b1; ex_rd = 0; ex_wdata = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 0; lsu_wdata = 32'h2;
    step();
    clr_in();
    step();
    check("x0_no_we", 32'(rd_we_o), 32'd0);
    step();

    // Reset with a buffered load and busy x4/x7.
    issue_lsu = 1'b1; issue_rd = 4;
    step();
    issue_rd = 7;
    step();
    clr_in(); lsu_valid = 1'b1; lsu_rd = 7; lsu_wdata = 32'h77;
    ex_valid = 1'b1; ex_rd = 10; ex_wdata = 32'h100;
    step();
    check("pre_rst_busy", busy_o, 32'h00000090);
    clr_in();
    rst_ni = 1'b0;
    #1;
    check("async_busy", busy_o, 32'd0);
    check("async_we", 32'(rd_we_o), 32'd0);
    check("async_ready", 32'(lsu_ready_o), 32'd0);
    step();
    rst_ni = 1'b1;
    #1 check("post_rst_ready", 32'(lsu_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic.
    pending = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        clr_in();
        pending = 1'b0;
        outst.delete();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        continue;
      end
      issue_lsu = ($urandom_range(0, 3) == 0);
      issue_rd  = AW'($urandom_range(0, 7));
      if (issue_lsu && issue_rd != 0) outst.push_back(issue_rd);
      if (!pending && outst.size() != 0 && $urandom_range(0, 1) == 1) begin
        pending = 1'b1; lsu_rd = outst.pop_front(); lsu_wdata = $urandom;
      end else if (!pending && $urandom_range(0, 15) == 0) begin
        pending = 1'b1; lsu_rd = '0; lsu_wdata = $urandom;
      end
      lsu_valid = pending;
      ex_valid  = ($urandom_range(0, 1) == 1);
      ex_rd     = AW'($urandom_range(0, 7));
      if (m_busy[ex_rd]) ex_rd = '0;
      ex_wdata  = $urandom;
      chk_rs1   = AW'($urandom_range(0, 7));
      chk_rs2   = AW'($urandom_range(0, 7));
      chk_rd    = AW'($urandom_range(0, 7));
      step();
      if (accepted) pending = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_writeback_stage.md
# rv32i_writeback_stage

Writeback stage feeding the `rv32i_register_file` write port: merges single-cycle execute results with long-latency LSU load results into one registered write per cycle. Holds one LSU result in a one-entry buffer. Maintains a per-register busy scoreboard so decode can stall on outstanding loads. Sits between EX/LSU and the register file; decode consumes `hazard_o`.

## Interface
- `XLEN_P`, default 32: data width.
- `DEPTH_P`, default 32: number of architectural registers; register 0 is x0.
- `ADDR_WIDTH_P`, default 5: register address width; must be ≥ clog2(`DEPTH_P`).

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `ex_valid_i`  in  1  single-cycle EX result valid; there is no ready, so the result is always taken.
- `ex_rd_addr_i`  in  ADDR_WIDTH_P  EX destination register.
- `ex_wdata_i`  in  XLEN_P  EX result data.
- `lsu_valid_i`  in  1  LSU load result valid.
- `lsu_ready_o`  out  1  stage can accept an LSU result.
- `lsu_rd_addr_i`  in  ADDR_WIDTH_P  load destination register.
- `lsu_wdata_i`  in  XLEN_P  load data.
- `issue_lsu_i`  in  1  a load is issued this cycle.
- `issue_rd_i`  in  ADDR_WIDTH_P  destination register of the issued load.
- `chk_rs1_i`, `chk_rs2_i`, `chk_rd_i`  in  ADDR_WIDTH_P each  decode operands to check.
- `hazard_o`  out  1  some checked register is busy.
- `busy_o`  out  DEPTH_P  scoreboard bits; bit 0 is always 0.
- `rd_we_o`  out  1  register-file write enable, registered.
- `rd_addr_o`  out  ADDR_WIDTH_P  register-file write address, registered.
- `rd_wdata_o`  out  XLEN_P  register-file write data, registered.

## Operation
**Definitions**
- `ex_write` = `ex_valid_i` && `ex_rd_addr_i` != 0.
- Hold buffer: `hold_valid_q`, `hold_addr_q`, `hold_data_q`.

**Write arbitration, evaluated each cycle**
- If `ex_write`: register {1, `ex_rd_addr_i`, `ex_wdata_i`} onto the `rd_*_o` outputs.
- Else if `hold_valid_q` && `hold_addr_q` != 0: register the hold contents onto the outputs. This is an LSU commit; the hold buffer empties.
- Else if `hold_valid_q` with address 0: drop the entry and empty the buffer; `rd_we_o` = 0.
- Else: `rd_we_o` = 0. `rd_addr_o`/`rd_wdata_o` keep their previous values.

**LSU handshake**
- `lsu_ready_o` = `rst_ni` && (!`hold_valid_q` || !`ex_write`). This is a combinational path from `ex_valid_i`.
- Accept when `lsu_valid_i` && `lsu_ready_o`: the hold buffer loads on that edge, which may be the same edge it drains.
- The LSU must hold valid, address and data stable until accepted.

**Scoreboard (`busy_q`)**
- Set `busy_q[issue_rd_i]` on the edge where `issue_lsu_i` is high and `issue_rd_i` != 0.
- Clear `busy_q[hold_addr_q]` on the edge of an LSU commit.
- Set and clear of the same register on the same edge: set wins, because a newer load is outstanding.
- Issuing to an already-busy register leaves the bit set.

**Hazard**
- `hazard_o` = `busy_q[chk_rs1_i]` | `busy_q[chk_rs2_i]` | `busy_q[chk_rd_i]`, combinational.
- Address 0 never hazards.
- Checking `chk_rd_i` prevents WAW against an outstanding load.

**Protocol assertions (non-synthesis)**
- `ex_write` to a register whose busy bit is set is an error.
- Any address ≥ `DEPTH_P` is an error.
- `lsu_valid_i` dropped while not yet accepted is an error.

## Timing
**Reset values**
- `rd_we_o`=0, `rd_addr_o`=0, `rd_wdata_o`=0.
- `busy_q`=0, `hold_valid_q`=0.
- `lsu_ready_o`=0 while `rst_ni` is low.

**Latency**
- EX result at cycle N: `rd_we_o` high in N+1 for exactly one cycle.
- LSU accepted at N: commits at the earliest cycle M ≥ N+1 without `ex_write`; `rd_we_o` is high in M+1.
- The busy bit clears at the same edge, so in M+1 `hazard_o` is already low. The register file's same-cycle bypass supplies the data to a reader in M+1.

**Throughput**
- One LSU result per cycle when EX is idle: hold drains and refills on the same edge.
- EX has strict priority. `ex_write` every cycle starves the LSU indefinitely; upstream guarantees bubbles.

**Reset mid-operation**
- Asserting `rst_ni` asynchronously clears the hold buffer, the scoreboard and all outputs.
- A buffered, uncommitted load is discarded.

## Test plan
- Reset, then EX writes x5=0xDEADBEEF at cycle 2 → `rd_we_o`=1, `rd_addr_o`=5, `rd_wdata_o`=0xDEADBEEF in cycle 3 only. All outputs are 0 during reset.
- Issue load to x7, then LSU returns 0x1234 with EX idle → `busy_o[7]`=1 and `hazard_o`=1 for `chk_rs1_i`=7 until commit. Write x7=0x1234 two cycles after the handshake; `busy_o[7]`=0 in that cycle.
- LSU result buffered while EX writes for 3 consecutive cycles → `lsu_ready_o`=0 during those cycles. LSU commits in the cycle after the EX writes end; the three EX writes appear in order before it.
- Back-to-back LSU results to x1, x2, x3 with EX idle → `lsu_ready_o` stays 1. Writes appear on consecutive cycles.
- Load to x4 commits on the same edge a new load to x4 issues → `busy_o[4]` remains 1. EX write to x0 and LSU result to x0 → `rd_we_o` never asserts.
- `rst_ni` low for 1 cycle with hold buffer full and `busy_o`=0x00000090 → after reset, `busy_o`=0, `lsu_ready_o`=1, and no write is ever emitted for the discarded load.
